// File: rtl/nonce_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : nonce_result_serializer
// Brief    : Captures {golden_nonce, hashed} on each rising edge of done and
//            streams it MSB byte first over a valid/ready byte link.
// Revision : 1.0 - initial release
// ============================================================================
module nonce_result_serializer #(
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 256,
  parameter int FCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                done,
  input  logic [NONCE_W-1:0]  golden_nonce,
  input  logic [HASH_W-1:0]   hashed,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                tx_last,
  output logic                busy,
  output logic                overrun,
  input  logic                clr_ovr,
  output logic [FCNT_W-1:0]   frame_cnt
);

  localparam int c_FW = NONCE_W + HASH_W;
  localparam int c_NB = c_FW / 8;
  localparam int c_IW = $clog2(c_NB + 1);
  localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_NB - 1);
  localparam logic [c_IW-1:0] c_PENULT   = c_IW'(c_NB - 2);
  localparam logic            c_ONE_BYTE = (c_NB == 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t             r_state;
  logic [c_FW-1:0]    r_active;
  logic [c_FW-1:0]    r_pending;
  logic               r_pend_v;
  logic               r_done_q;
  logic               r_tx_last;
  logic               r_overrun;
  logic [c_IW-1:0]    r_byte_idx;
  logic [FCNT_W-1:0]  r_frame_cnt;

  logic               w_cap;
  logic               w_hs;
  logic               w_last_hs;
  logic               w_drop;
  logic [c_FW-1:0]    w_result;

  assign w_result  = {golden_nonce, hashed};
  assign w_cap     = done & ~r_done_q;
  assign w_hs      = (r_state == S_SEND) & tx_ready;
  assign w_last_hs = w_hs & (r_byte_idx == c_LAST_IDX);
  // A result arriving while both slots are occupied is the only drop case.
  assign w_drop    = (r_state == S_SEND) & w_cap & r_pend_v & ~w_last_hs;

  assign tx_data   = r_active[c_FW-1 -: 8];
  assign tx_valid  = (r_state == S_SEND);
  assign tx_last   = r_tx_last;
  assign busy      = (r_state == S_SEND) | r_pend_v;
  assign overrun   = r_overrun;
  assign frame_cnt = r_frame_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_v    <= 1'b0;
      r_done_q    <= 1'b1;   // a level already high at reset is not an edge
      r_tx_last   <= 1'b0;
      r_overrun   <= 1'b0;
      r_byte_idx  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_done_q <= done;

      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_cap) begin
            r_active   <= w_result;
            r_byte_idx <= '0;
            r_tx_last  <= c_ONE_BYTE;
            r_state    <= S_SEND;
          end
        end

        S_SEND: begin
          if (w_last_hs) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
            r_byte_idx  <= '0;
            r_tx_last   <= c_ONE_BYTE;
            if (r_pend_v) begin
              r_active <= r_pending;
              if (w_cap) begin
                r_pending <= w_result;
              end else begin
                r_pend_v <= 1'b0;
              end
            end else if (w_cap) begin
              r_active <= w_result;
            end else begin
              r_state   <= S_IDLE;
              r_tx_last <= 1'b0;
            end
          end else begin
            if (w_hs) begin
              r_active   <= {r_active[c_FW-9:0], 8'h00};
              r_byte_idx <= r_byte_idx + 1'b1;
              r_tx_last  <= (r_byte_idx == c_PENULT);
            end
            if (w_cap && !r_pend_v) begin
              r_pending <= w_result;
              r_pend_v  <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nonce_result_serializer
// Brief    : Directed self-checking bench for nonce_result_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nonce_result_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         done = 1'b0;
  logic [31:0]  golden_nonce = '0;
  logic [255:0] hashed = '0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic         tx_last;
  logic         busy;
  logic         overrun;
  logic         clr_ovr = 1'b0;
  logic [15:0]  frame_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0] rx [0:63];
  logic       rx_last [0:63];

  nonce_result_serializer #(.NONCE_W(32), .HASH_W(256), .FCNT_W(16)) dut (
    .clk(clk), .rst(rst), .done(done), .golden_nonce(golden_nonce),
    .hashed(hashed), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy), .overrun(overrun),
    .clr_ovr(clr_ovr), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the capture posedge follows, and returns one negedge later.
  task automatic pulse(input logic [31:0] n, input logic [255:0] h);
    golden_nonce = n;
    hashed       = h;
    done         = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  // mode 0: tx_ready always 1, mode 1: toggles. inj_at>=0 raises done while
  // byte inj_at is being handshaked.
  task automatic collect(input int mode, input int inj_at, input logic [31:0] inj_n,
                         input logic [255:0] inj_h, output int n);
    int   cyc = 0;
    bit   fin = 0;
    bit   stalled = 0;
    bit   injd = 0;
    logic [7:0] held = '0;
    n = 0;
    while (!fin && cyc < 400) begin
      tx_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      if (inj_at >= 0) begin
        if (!injd && tx_valid && tx_ready && n == inj_at) begin
          golden_nonce = inj_n;
          hashed       = inj_h;
          done         = 1'b1;
          injd         = 1;
        end else begin
          done = 1'b0;
        end
      end
      if (tx_valid && stalled) chk("stall_hold", tx_data, held);
      if (tx_valid && tx_ready) begin
        if (n < 64) begin
          rx[n]      = tx_data;
          rx_last[n] = tx_last;
        end
        n++;
        stalled = 0;
        if (tx_last) fin = 1;
      end else if (tx_valid) begin
        stalled = 1;
        held    = tx_data;
      end
      @(negedge clk);
      cyc++;
    end
    if (inj_at >= 0) done = 1'b0;
    chk("collect_timeout", fin, 1'b1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] nn,
                             input logic [255:0] hh, input int n);
    logic [287:0] f;
    int bad = 0;
    int lbad = 0;
    f = {nn, hh};
    for (int i = 0; i < 36; i++) begin
      if (i < n) begin
        if (rx[i] !== f[287-8*i -: 8]) bad++;
        if (rx_last[i] !== (i == 35)) lbad++;
      end
    end
    chk({tag, "_len"}, 64'(n), 64'd36);
    chk({tag, "_bytes"}, 64'(bad), 64'd0);
    chk({tag, "_last"}, 64'(lbad), 64'd0);
  endtask

  initial begin
    int n;
    logic [255:0] h_ab, h_seq, h_a, h_b, h_c;
    logic [287:0] f6;
    logic [7:0]   b10;
    h_ab = {32{8'hAB}};
    h_a  = {8{32'h01020304}};
    h_b  = {8{32'hCAFEF00D}};
    h_c  = {8{32'h99887766}};
    for (int i = 0; i < 32; i++) h_seq[255-8*i -: 8] = 8'(8'h20 + i);

    // Reset state
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_last", tx_last, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single result, full throughput
    tx_ready = 1'b1;
    pulse(32'h0000_0004, h_ab);
    chk("c1_valid_rise", tx_valid, 1'b1);
    chk("c1_first_byte", tx_data, 8'h00);
    collect(0, -1, '0, '0, n);
    check_frame("c1", 32'h0000_0004, h_ab, n);
    chk("c1_frame_cnt", frame_cnt, 16'd1);
    chk("c1_idle_valid", tx_valid, 1'b0);
    chk("c1_idle_busy", busy, 1'b0);

    // 2: backpressure toggling every cycle
    tx_ready = 1'b0;
    pulse(32'h0000_0004, h_ab);
    collect(1, -1, '0, '0, n);
    check_frame("c2", 32'h0000_0004, h_ab, n);
    chk("c2_frame_cnt", frame_cnt, 16'd2);

    // 3: three results while stalled -> one active, one pending, one dropped
    tx_ready = 1'b0;
    @(negedge clk);
    pulse(32'h1122_3344, h_a);
    repeat (10) @(negedge clk);
    pulse(32'h5566_7788, h_b);
    repeat (10) @(negedge clk);
    pulse(32'h99AA_BBCC, h_c);
    @(negedge clk);
    chk("c3_overrun", overrun, 1'b1);
    chk("c3_busy", busy, 1'b1);
    chk("c3_head", tx_data, 8'h11);
    collect(0, -1, '0, '0, n);
    check_frame("c3a", 32'h1122_3344, h_a, n);
    chk("c3_no_bubble", tx_valid, 1'b1);
    collect(0, -1, '0, '0, n);
    check_frame("c3b", 32'h5566_7788, h_b, n);
    repeat (3) @(negedge clk);
    chk("c3_idle_valid", tx_valid, 1'b0);
    chk("c3_frame_cnt", frame_cnt, 16'd4);
    chk("c3_overrun_sticky", overrun, 1'b1);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    chk("c3_overrun_clr", overrun, 1'b0);

    // 4: capture coincident with last-byte handshake, pending empty
    tx_ready = 1'b1;
    pulse(32'hDEAD_BEEF, h_ab);
    collect(0, 35, 32'hCAFE_0001, h_seq, n);
    check_frame("c4a", 32'hDEAD_BEEF, h_ab, n);
    chk("c4_no_drop", tx_valid, 1'b1);
    chk("c4_next_head", tx_data, 8'hCA);
    chk("c4_cnt_mid", frame_cnt, 16'd5);
    collect(0, -1, '0, '0, n);
    check_frame("c4b", 32'hCAFE_0001, h_seq, n);
    chk("c4_frame_cnt", frame_cnt, 16'd6);
    chk("c4_no_overrun", overrun, 1'b0);

    // 5: done high across reset release
    rst = 1'b0;
    golden_nonce = 32'h0BAD_F00D;
    hashed = h_b;
    done = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("c5_no_frame", tx_valid, 1'b0);
    chk("c5_busy", busy, 1'b0);
    done = 1'b0;
    @(negedge clk);
    golden_nonce = 32'h0BAD_F00D;
    done = 1'b1;
    @(negedge clk);
    chk("c5_valid", tx_valid, 1'b1);
    collect(0, -1, '0, '0, n);
    check_frame("c5", 32'h0BAD_F00D, h_b, n);
    repeat (3) @(negedge clk);
    chk("c5_single", tx_valid, 1'b0);
    chk("c5_frame_cnt", frame_cnt, 16'd1);
    done = 1'b0;
    @(negedge clk);

    // 6: reset in the middle of a frame
    tx_ready = 1'b1;
    pulse(32'h7654_3210, h_seq);
    repeat (10) @(negedge clk);
    f6  = {32'h7654_3210, h_seq};
    b10 = f6[287-80 -: 8];
    chk("c6_byte10", tx_data, b10);
    rst = 1'b0;
    #1;
    chk("c6_rst_valid", tx_valid, 1'b0);
    chk("c6_rst_data", tx_data, 8'h00);
    chk("c6_rst_last", tx_last, 1'b0);
    chk("c6_rst_busy", busy, 1'b0);
    chk("c6_rst_cnt", frame_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    pulse(32'h0000_0004, h_ab);
    collect(0, -1, '0, '0, n);
    check_frame("c6", 32'h0000_0004, h_ab, n);
    chk("c6_frame_cnt", frame_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
